ball_motion_ctrl: RTL and testbench

- Sequences the ball position datapath once per frame tick: serve, straight-line stepping, wall and paddle reflection, and miss detection.
- Produces the ball x/y coordinates consumed by the heading detector and the renderer, plus heading bits and hit/miss event pulses for score logic.
- Sits between the frame timing generator (tick) and the pixel/drawing stage.

---
 rtl/ball_pkg.sv | 27 ++
 rtl/ball_motion_ctrl_axis_step.sv | 58 +++++
 rtl/ball_motion_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: shared types and default geometry for the ball motion controller.
//   - ball_state_e : controller FSM states (IDLE, MOVE, MISS)
//   - COORD_W      : width of screen coordinates
//   - CALC_W       : one bit wider than COORD_W so that pos+speed cannot wrap
//   - *_DEF        : default screen / paddle / serve geometry
package ball_pkg;

  localparam int COORD_W = 11;
  localparam int CALC_W  = COORD_W + 1;

  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H_DEF  = 480;
  localparam int BALL_SIZE_DEF = 8;
  localparam int PADDLE_Y_DEF  = 464;
  localparam int PADDLE_W_DEF  = 64;
  localparam int START_X_DEF   = 60;
  localparam int START_Y_DEF   = 60;
  localparam int STEP_DEF      = 2;
  localparam int MAX_STEP_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    MISS = 2'd2
  } ball_state_e;

endpackage

// File: rtl/ball_motion_ctrl_axis_step.sv
// axis_step: combinational single-axis stepper with reflection at [lo, hi].
// Ports:
//   pos      in   current coordinate
//   dir      in   heading, 1 = increasing
//   speed    in   pixels per step
//   lo, hi   in   inclusive travel limits
//   next_pos out  coordinate after one step (clamped to the limit on reflection)
//   next_dir out  heading after one step
//   edge_hi  out  step would reach/cross hi; lets the caller override the
//                 high-side decision (y axis: paddle or miss)
module axis_step
  import ball_pkg::*;
#(
  parameter int SPD_W = 4
) (
  input  logic [COORD_W-1:0] pos,
  input  logic               dir,
  input  logic [SPD_W-1:0]   speed,
  input  logic [COORD_W-1:0] lo,
  input  logic [COORD_W-1:0] hi,
  output logic [COORD_W-1:0] next_pos,
  output logic               next_dir,
  output logic               edge_hi
);

  logic [CALC_W-1:0] pos_w, spd_w, lo_w, hi_w, up_w, dn_w;

  // Everything is compared in CALC_W bits so pos+speed never wraps.
  assign pos_w = CALC_W'(pos);
  assign spd_w = CALC_W'(speed);
  assign lo_w  = CALC_W'(lo);
  assign hi_w  = CALC_W'(hi);
  assign up_w  = pos_w + spd_w;
  assign dn_w  = pos_w - spd_w;

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    edge_hi  = 1'b0;
    if (dir) begin
      if (up_w >= hi_w) begin
        next_pos = hi;
        next_dir = 1'b0;
        edge_hi  = 1'b1;
      end else begin
        next_pos = up_w[COORD_W-1:0];
      end
    end else begin
      if (pos_w < lo_w + spd_w) begin
        next_pos = lo;
        next_dir = 1'b1;
      end else begin
        next_pos = dn_w[COORD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame ball sequencer (serve, step, wall/paddle
// reflection, miss detection).
// Optional feature macro: BALL_SPEEDUP_EN -- speed grows by 1 per paddle hit,
// saturating at MAX_STEP, and reloads to STEP on serve, miss and reset. When
// undefined the speed is the constant STEP.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   tick       one-cycle frame strobe; advances the ball in MOVE
//   serve      launch request, only honoured in IDLE
//   paddle_x   paddle left edge
//   x, y       ball top-left corner (registered, 1 cycle after tick)
//   xh, yh     headings, 1 = increasing
//   active     high in MOVE
//   hit        one-cycle pulse, coincident with the reflected position
//   miss       one-cycle pulse, ball lost (y shown clamped at the bottom)
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int PADDLE_Y  = PADDLE_Y_DEF,
  parameter int PADDLE_W  = PADDLE_W_DEF,
  parameter int START_X   = START_X_DEF,
  parameter int START_Y   = START_Y_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int MAX_STEP  = MAX_STEP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               serve,
  input  logic [COORD_W-1:0] paddle_x,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               xh,
  output logic               yh,
  output logic               active,
  output logic               hit,
  output logic               miss
);

  // Speed register is sized for the ceiling so both builds share one width.
  localparam int SPD_W = $clog2(MAX_STEP + 1);

  localparam logic [COORD_W-1:0] X_HI   = COORD_W'(SCREEN_W - BALL_SIZE);
  localparam logic [COORD_W-1:0] Y_HI   = COORD_W'(PADDLE_Y - BALL_SIZE);
  localparam logic [CALC_W-1:0]  Y_PAD  = CALC_W'(PADDLE_Y - BALL_SIZE);
  localparam logic [CALC_W-1:0]  Y_BOT  = CALC_W'(SCREEN_H - BALL_SIZE);
  localparam logic [COORD_W-1:0] X_ST   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_ST   = COORD_W'(START_Y);
  localparam logic [SPD_W-1:0]   SPD_ST = SPD_W'(STEP);

  ball_state_e        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               xh_q, xh_d, yh_q, yh_d;
  logic               hit_q, hit_d;
  logic [SPD_W-1:0]   speed;

`ifdef BALL_SPEEDUP_EN
  logic [SPD_W-1:0]   speed_q, speed_d;
  assign speed = speed_q;
`else
  assign speed = SPD_ST;
`endif

  // Per-axis steppers. y's high limit is the paddle top; the controller
  // decides between hit, pass-through and miss when y reaches it.
  logic [COORD_W-1:0] xs_pos, ys_pos;
  logic               xs_dir, ys_dir, ys_edge, x_edge_unused;

  axis_step #(.SPD_W(SPD_W)) u_x_step (
    .pos      (x_q),
    .dir      (xh_q),
    .speed    (speed),
    .lo       ('0),
    .hi       (X_HI),
    .next_pos (xs_pos),
    .next_dir (xs_dir),
    .edge_hi  (x_edge_unused)
  );

  axis_step #(.SPD_W(SPD_W)) u_y_step (
    .pos      (y_q),
    .dir      (yh_q),
    .speed    (speed),
    .lo       ('0),
    .hi       (Y_HI),
    .next_pos (ys_pos),
    .next_dir (ys_dir),
    .edge_hi  (ys_edge)
  );

  // Paddle overlap on the pre-step x, in CALC_W bits to avoid wrap.
  logic [CALC_W-1:0] x_w, y_w, px_w, y_up;
  logic              overlap;

  assign x_w     = CALC_W'(x_q);
  assign y_w     = CALC_W'(y_q);
  assign px_w    = CALC_W'(paddle_x);
  assign y_up    = y_w + CALC_W'(speed);
  assign overlap = (x_w + CALC_W'(BALL_SIZE) > px_w) &&
                   (x_w < px_w + CALC_W'(PADDLE_W));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xh_d    = xh_q;
    yh_d    = yh_q;
    hit_d   = 1'b0;
`ifdef BALL_SPEEDUP_EN
    speed_d = speed_q;
`endif
    case (state_q)
      IDLE: begin
        // Parked; ticks ignored. Serve wins over a coincident tick.
        x_d  = X_ST;
        y_d  = Y_ST;
        xh_d = 1'b1;
        yh_d = 1'b1;
        if (serve) begin
          state_d = MOVE;
`ifdef BALL_SPEEDUP_EN
          speed_d = SPD_ST;
`endif
        end
      end
      MOVE: begin
        if (tick) begin
          x_d  = xs_pos;
          xh_d = xs_dir;
          if (ys_edge) begin
            // Hit only while the ball has not yet sunk below the paddle top;
            // a hit takes priority over a miss on the same tick.
            if (overlap && (y_w <= Y_PAD)) begin
              y_d   = Y_HI;
              yh_d  = 1'b0;
              hit_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
              if (speed_q < SPD_W'(MAX_STEP)) speed_d = speed_q + 1'b1;
`endif
            end else if (y_up >= Y_BOT) begin
              y_d     = Y_BOT[COORD_W-1:0];
              state_d = MISS;
            end else begin
              y_d = y_up[COORD_W-1:0];
            end
          end else begin
            y_d  = ys_pos;
            yh_d = ys_dir;
          end
        end
      end
      MISS: begin
        x_d     = X_ST;
        y_d     = Y_ST;
        xh_d    = 1'b1;
        yh_d    = 1'b1;
        state_d = IDLE;
`ifdef BALL_SPEEDUP_EN
        speed_d = SPD_ST;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= X_ST;
      y_q     <= Y_ST;
      xh_q    <= 1'b1;
      yh_q    <= 1'b1;
      hit_q   <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      speed_q <= SPD_ST;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xh_q    <= xh_d;
      yh_q    <= yh_d;
      hit_q   <= hit_d;
`ifdef BALL_SPEEDUP_EN
      speed_q <= speed_d;
`endif
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign xh     = xh_q;
  assign yh     = yh_q;
  assign hit    = hit_q;
  assign miss   = (state_q == MISS);
  assign active = (state_q == MOVE);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: idle parking, serve and first steps,
// miss at the bottom, paddle hit, right wall, top wall and mid-move reset.
module tb_ball_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        serve = 1'b0;
  logic [10:0] paddle_x = '0;
  logic [10:0] x, y;
  logic        xh, yh, active, hit, miss;

  int n_chk = 0;
  int n_err = 0;

  ball_motion_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .serve    (serve),
    .paddle_x (paddle_x),
    .x        (x),
    .y        (y),
    .xh       (xh),
    .yh       (yh),
    .active   (active),
    .hit      (hit),
    .miss     (miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int ex, input int ey,
                         input int exh, input int eyh);
    check({tag, ".x"},  int'(x),  ex);
    check({tag, ".y"},  int'(y),  ey);
    check({tag, ".xh"}, int'(xh), exh);
    check({tag, ".yh"}, int'(yh), eyh);
  endtask

  // One tick pulse; returns on the following falling edge with new state visible.
  task automatic step();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_pos("rst", 60, 60, 1, 1);
    check("rst.active", int'(active), 0);
    check("rst.hit", int'(hit), 0);
    check("rst.miss", int'(miss), 0);
    rst = 1'b0;

    // Ticks in IDLE are ignored
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle.hit", int'(hit), 0);
      check("idle.miss", int'(miss), 0);
    end
    chk_pos("idle", 60, 60, 1, 1);
    check("idle.active", int'(active), 0);

    // Serve with a coincident tick: serve wins, no step yet
    @(negedge clk) begin serve = 1'b1; tick = 1'b1; end
    @(negedge clk) begin serve = 1'b0; tick = 1'b0; end
    check("serve.active", int'(active), 1);
    chk_pos("serve", 60, 60, 1, 1);

    step();
    chk_pos("t1", 62, 62, 1, 1);
    repeat (3) @(negedge clk);
    chk_pos("notick", 62, 62, 1, 1);
    step();
    chk_pos("t2", 64, 64, 1, 1);
    step();
    chk_pos("t3", 66, 66, 1, 1);

    // Paddle far left: ball passes the paddle line and is lost
    paddle_x = 11'd0;
    steps(202);
    chk_pos("t205", 470, 470, 1, 1);
    step();
    check("miss.y", int'(y), 472);
    check("miss.x", int'(x), 472);
    check("miss.pulse", int'(miss), 1);
    check("miss.hit", int'(hit), 0);
    check("miss.active", int'(active), 0);
    @(negedge clk);
    chk_pos("postmiss", 60, 60, 1, 1);
    check("postmiss.miss", int'(miss), 0);
    check("postmiss.active", int'(active), 0);

    // Paddle under the ball: reflection and hit pulse
    paddle_x = 11'd420;
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
    check("serve2.active", int'(active), 1);
    steps(197);
    chk_pos("prehit", 454, 454, 1, 1);
    step();
    chk_pos("hit", 456, 456, 1, 0);
    check("hit.pulse", int'(hit), 1);
    check("hit.miss", int'(miss), 0);
    @(negedge clk);
    check("hit.end", int'(hit), 0);
    check("hit.hold", int'(y), 456);

`ifdef BALL_SPEEDUP_EN
    // Speed is now STEP+1
    step();
    chk_pos("fast", 459, 453, 1, 0);
`else
    // Right wall clamp and reflection
    steps(87);
    chk_pos("prewall", 630, 282, 1, 0);
    step();
    chk_pos("wall", 632, 280, 0, 0);
    step();
    chk_pos("postwall", 630, 278, 0, 0);

    // Top wall: reach 0, then reflect on the next tick
    steps(139);
    chk_pos("top0", 352, 0, 0, 0);
    step();
    chk_pos("topref", 350, 0, 0, 1);
    step();
    chk_pos("topdn", 348, 2, 0, 1);
`endif

    // Reset for a single cycle mid-move
    check("premrst.active", int'(active), 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk_pos("midrst", 60, 60, 1, 1);
    check("midrst.active", int'(active), 0);
    check("midrst.hit", int'(hit), 0);
    step();
    chk_pos("midrst.tick", 60, 60, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
